irq_gen: RTL and testbench

Interrupt generator that sits directly downstream of the interrupt-collapsing stage and drives the Virtex-5 PCIe endpoint's legacy/MSI interrupt request interface. It latches single-cycle "data ready" notifications and holds them as one pending interrupt. A driver-controlled arm/disarm gate and a programmable hold-off timer moderate the interrupt rate. Only once the endpoint completes the interrupt handshake is the upstream stage acknowledged.

---
 rtl/irq_gen.sv | 157 +++++++++++++++
 tb/tb_irq_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_gen.sv
// -----------------------------------------------------------------------------
// irq_gen
//
// Interrupt generator between the interrupt-collapsing stage and the PCIe
// endpoint's legacy/MSI request interface. A single-cycle data_rdy notification
// is latched as one pending interrupt. The interrupt is requested only while the
// driver has armed the generator and the host has enabled MSI. Once the endpoint
// accepts the request, the upstream stage is acknowledged and a hold-off timer
// enforces a minimum gap before the next request.
//
// Parameters:
//   HOLDOFF_CYCLES  idle cycles enforced after each delivered interrupt
//   TIMER_W         hold-off counter width (HOLDOFF_CYCLES < 2**TIMER_W)
//
// Ports:
//   clk                      core clock, rising edge
//   rst                      synchronous active-high reset
//   data_rdy                 one-cycle notification from the collapsing stage
//   data_rdy_ack             one-cycle pulse: pending interrupt delivered
//   irq_en                   one-cycle pulse: arm the generator
//   irq_dis                  one-cycle pulse: disarm the generator
//   cfg_interrupt_msienable  endpoint config: MSI enabled by host
//   cfg_interrupt_n          active-low interrupt request to the endpoint
//   cfg_interrupt_rdy_n      active-low endpoint accept
//   irq_pending              status: interrupt latched, not yet delivered
//   irq_armed                status: arm flag
//   irq_count                delivered-interrupt count, wraps to 0
// -----------------------------------------------------------------------------
module irq_gen #(
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int TIMER_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_rdy,
    output logic        data_rdy_ack,
    input  logic        irq_en,
    input  logic        irq_dis,
    input  logic        cfg_interrupt_msienable,
    output logic        cfg_interrupt_n,
    input  logic        cfg_interrupt_rdy_n,
    output logic        irq_pending,
    output logic        irq_armed,
    output logic [31:0] irq_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] HOLDOFF_LOAD = TIMER_W'(HOLDOFF_CYCLES);

    state_t              state_q, state_d;
    logic                cfg_int_n_q, cfg_int_n_d;
    logic                ack_q, ack_d;
    logic                pending_q, pending_d;
    logic                armed_q, armed_d;
    logic [31:0]         count_q, count_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                handshake;

    always_comb begin
        state_d     = state_q;
        cfg_int_n_d = cfg_int_n_q;
        ack_d       = 1'b0;
        count_d     = count_q;
        timer_d     = timer_q;

        // The endpoint's accept only matters while a request is outstanding.
        handshake = (state_q == S_REQ) && !cfg_interrupt_rdy_n;

        // irq_dis beats irq_en; a fresh irq_en beats the handshake's auto-disarm
        // so that it arms the following interrupt.
        if (irq_dis) begin
            armed_d = 1'b0;
        end else if (irq_en) begin
            armed_d = 1'b1;
        end else if (handshake) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end

        // A notification arriving with the handshake starts a new pending interrupt.
        if (data_rdy) begin
            pending_d = 1'b1;
        end else if (handshake) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            S_IDLE: begin
                cfg_int_n_d = 1'b1;
                if (pending_q && armed_q && cfg_interrupt_msienable) begin
                    state_d     = S_REQ;
                    cfg_int_n_d = 1'b0;
                end
            end
            S_REQ: begin
                // Once raised, the request is held until accepted regardless of
                // irq_dis or MSI enable; the endpoint cannot take a withdrawal.
                if (handshake) begin
                    state_d     = S_HOLDOFF;
                    cfg_int_n_d = 1'b1;
                    ack_d       = 1'b1;
                    count_d     = count_q + 32'd1;
                    timer_d     = HOLDOFF_LOAD;
                end else begin
                    cfg_int_n_d = 1'b0;
                end
            end
            S_HOLDOFF: begin
                cfg_int_n_d = 1'b1;
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                cfg_int_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_int_n_q <= 1'b1;
            ack_q       <= 1'b0;
            pending_q   <= 1'b0;
            armed_q     <= 1'b0;
            count_q     <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cfg_int_n_q <= cfg_int_n_d;
            ack_q       <= ack_d;
            pending_q   <= pending_d;
            armed_q     <= armed_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
        end
    end

    assign cfg_interrupt_n = cfg_int_n_q;
    assign data_rdy_ack    = ack_q;
    assign irq_pending     = pending_q;
    assign irq_armed       = armed_q;
    assign irq_count       = count_q;

endmodule

// File: tb/tb_irq_gen.sv
// -----------------------------------------------------------------------------
// tb_irq_gen
//
// Bench for irq_gen with a 16-cycle hold-off. A reference model tracks the
// pending/armed flags, whether a request is outstanding, and the earliest edge
// at which a new request may be raised (a timestamp, not a countdown). Each
// modelled delivery pushes the expected interrupt count into a scoreboard
// queue; a negedge monitor pops it whenever the DUT pulses data_rdy_ack and
// also compares the visible outputs against the model every cycle. Directed
// scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_irq_gen;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_rdy = 1'b0;
    logic        irq_en = 1'b0;
    logic        irq_dis = 1'b0;
    logic        msi = 1'b1;
    logic        rdy_n = 1'b0;
    logic        data_rdy_ack;
    logic        cfg_interrupt_n;
    logic        irq_pending;
    logic        irq_armed;
    logic [31:0] irq_count;

    irq_gen #(.HOLDOFF_CYCLES(H), .TIMER_W(16)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .data_rdy                (data_rdy),
        .data_rdy_ack            (data_rdy_ack),
        .irq_en                  (irq_en),
        .irq_dis                 (irq_dis),
        .cfg_interrupt_msienable (msi),
        .cfg_interrupt_n         (cfg_interrupt_n),
        .cfg_interrupt_rdy_n     (rdy_n),
        .irq_pending             (irq_pending),
        .irq_armed               (irq_armed),
        .irq_count               (irq_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pend = 1'b0;
    bit          m_armed = 1'b0;
    bit          m_req = 1'b0;
    bit          m_ack = 1'b0;
    int unsigned m_count = 0;
    longint      cyc = 0;
    longint      m_idle_from = 0;
    int unsigned sb_q[$];
    bit          m_hs;
    bit          m_start;
    bit          mon_on = 1'b0;

    // Delivery happens when an outstanding request sees the endpoint accept.
    assign m_hs    = m_req && !rdy_n;
    // A request may be raised once the post-delivery quiet window is over.
    assign m_start = !m_req && (cyc >= m_idle_from) && m_pend && m_armed && msi;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_pend      <= 1'b0;
            m_armed     <= 1'b0;
            m_req       <= 1'b0;
            m_ack       <= 1'b0;
            m_count     <= 0;
            m_idle_from <= 0;
        end else begin
            m_ack <= m_hs;
            if (m_hs) begin
                m_count     <= m_count + 1;
                m_req       <= 1'b0;
                m_idle_from <= cyc + H + 2;
                sb_q.push_back(m_count + 1);
            end else if (m_start) begin
                m_req <= 1'b1;
            end
            m_armed <= irq_dis ? 1'b0 : (irq_en ? 1'b1 : (m_hs ? 1'b0 : m_armed));
            m_pend  <= data_rdy ? 1'b1 : (m_hs ? 1'b0 : m_pend);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            chk1("cyc_cfg_interrupt_n", cfg_interrupt_n, !m_req);
            chk1("cyc_data_rdy_ack", data_rdy_ack, m_ack);
            chk1("cyc_irq_pending", irq_pending, m_pend);
            chk1("cyc_irq_armed", irq_armed, m_armed);
            chk32("cyc_irq_count", irq_count, m_count);
            if (data_rdy_ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_ack: got ack with count %0d, expected no ack at %0t",
                             irq_count, $time);
                end else begin
                    chk32("sb_ack_count", irq_count, sb_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        data_rdy = 1'b0;
        irq_en   = 1'b0;
        irq_dis  = 1'b0;
    endtask

    initial begin
        bit low_seen;
        int n_low;
        int acks;
        int n;
        bit found;

        // Reset values
        rst = 1'b1;
        cycle();
        mon_on = 1'b1;
        cycle();
        chk1("rst_cfg_interrupt_n", cfg_interrupt_n, 1'b1);
        chk1("rst_data_rdy_ack", data_rdy_ack, 1'b0);
        chk1("rst_irq_pending", irq_pending, 1'b0);
        chk1("rst_irq_armed", irq_armed, 1'b0);
        chk32("rst_irq_count", irq_count, 0);
        rst = 1'b0;

        // Basic delivery with endpoint accepting immediately
        rdy_n = 1'b0;
        irq_en = 1'b1;
        cycle();
        chk1("t1_armed", irq_armed, 1'b1);
        data_rdy = 1'b1;
        cycle();
        chk1("t1_pending", irq_pending, 1'b1);
        chk1("t1_req_not_yet", cfg_interrupt_n, 1'b1);
        cycle();
        chk1("t1_req_low", cfg_interrupt_n, 1'b0);
        chk1("t1_no_ack_yet", data_rdy_ack, 1'b0);
        cycle();
        chk1("t1_req_released", cfg_interrupt_n, 1'b1);
        chk1("t1_ack", data_rdy_ack, 1'b1);
        chk1("t1_pending_clr", irq_pending, 1'b0);
        chk1("t1_armed_clr", irq_armed, 1'b0);
        chk32("t1_count", irq_count, 1);
        cycle();
        chk1("t1_ack_one_cycle", data_rdy_ack, 1'b0);
        repeat (H + 4) cycle();

        // Notification while disarmed is held; arming releases it
        data_rdy = 1'b1;
        low_seen = 1'b0;
        repeat (500) begin
            cycle();
            if (cfg_interrupt_n !== 1'b1) low_seen = 1'b1;
        end
        chk1("t2_no_req_disarmed", low_seen, 1'b0);
        chk1("t2_pending_held", irq_pending, 1'b1);
        irq_en = 1'b1;
        cycle();
        chk1("t2_req_not_yet", cfg_interrupt_n, 1'b1);
        cycle();
        chk1("t2_req_low", cfg_interrupt_n, 1'b0);
        cycle();
        chk1("t2_ack", data_rdy_ack, 1'b1);
        chk32("t2_count", irq_count, 2);
        repeat (H + 4) cycle();

        // Endpoint stalls 7 cycles; irq_dis mid-request does not withdraw it
        rdy_n = 1'b1;
        irq_en = 1'b1;
        cycle();
        data_rdy = 1'b1;
        cycle();
        cycle();
        chk1("t3_req_low", cfg_interrupt_n, 1'b0);
        n_low = 0;
        acks = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) irq_dis = 1'b1;
            cycle();
            if (cfg_interrupt_n === 1'b0) n_low++;
            if (data_rdy_ack === 1'b1) acks++;
        end
        chk32("t3_held_low", n_low, 7);
        rdy_n = 1'b0;
        cycle();
        chk1("t3_ack", data_rdy_ack, 1'b1);
        chk1("t3_req_released", cfg_interrupt_n, 1'b1);
        chk1("t3_armed", irq_armed, 1'b0);
        chk32("t3_count", irq_count, 3);

        // Immediate re-arm and new notification: next request after H+2 edges
        irq_en = 1'b1;
        data_rdy = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            n++;
            if (data_rdy_ack === 1'b1) acks++;
            if (cfg_interrupt_n === 1'b0) found = 1'b1;
        end
        chk32("t3_no_extra_ack", acks, 0);
        chk1("t4_req_seen", found, 1'b1);
        chk32("t4_holdoff_gap", n, H + 2);
        cycle();
        chk1("t4_ack", data_rdy_ack, 1'b1);
        chk32("t4_count", irq_count, 4);
        repeat (H + 4) cycle();

        // irq_dis beats irq_en; MSI disabled holds the request back
        irq_en = 1'b1;
        irq_dis = 1'b1;
        cycle();
        chk1("t5_dis_wins", irq_armed, 1'b0);
        msi = 1'b0;
        irq_en = 1'b1;
        cycle();
        data_rdy = 1'b1;
        cycle();
        low_seen = 1'b0;
        repeat (30) begin
            cycle();
            if (cfg_interrupt_n !== 1'b1) low_seen = 1'b1;
        end
        chk1("t5_no_req_msi_off", low_seen, 1'b0);
        msi = 1'b1;
        cycle();
        chk1("t5_req_after_msi", cfg_interrupt_n, 1'b0);
        cycle();
        chk1("t5_ack", data_rdy_ack, 1'b1);
        chk32("t5_count", irq_count, 5);
        repeat (H + 4) cycle();

        // Reset while a request is outstanding
        rdy_n = 1'b1;
        irq_en = 1'b1;
        cycle();
        data_rdy = 1'b1;
        cycle();
        cycle();
        chk1("t6_req_low", cfg_interrupt_n, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk1("t6_cfg_interrupt_n", cfg_interrupt_n, 1'b1);
        chk1("t6_no_ack", data_rdy_ack, 1'b0);
        chk1("t6_pending", irq_pending, 1'b0);
        chk1("t6_armed", irq_armed, 1'b0);
        chk32("t6_count", irq_count, 0);
        rdy_n = 1'b0;
        acks = 0;
        repeat (10) begin
            cycle();
            if (data_rdy_ack === 1'b1) acks++;
        end
        chk32("t6_no_ack_after_rst", acks, 0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            rst      = ($urandom_range(0, 499) == 0);
            data_rdy = ($urandom_range(0, 5) == 0);
            irq_en   = ($urandom_range(0, 7) == 0);
            irq_dis  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) msi = ~msi;
            rdy_n    = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst   = 1'b0;
        msi   = 1'b1;
        rdy_n = 1'b0;
        irq_en = 1'b1;
        repeat (H + 40) cycle();
        chk32("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
